// File: rtl/sum_stream_pkg.sv
// Shared types and constants for the sum stream (adder -> window accumulator -> display).
package sum_stream_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    localparam int SUM_W              = 5;
    localparam int DEFAULT_ACC_W      = 8;
    localparam int DEFAULT_WINDOW     = 16;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    function automatic int acc_max(input int acc_w);
        return (1 << acc_w) - 1;
    endfunction

endpackage

// File: rtl/sum_sync_fifo.sv
// Small synchronous FIFO with occupancy level; the read word is shown combinationally at the head.
module sum_sync_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only pointers and level define contents.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sum_window_accumulator.sv
// Buffers adder sums and emits a saturating total per window of WINDOW samples (or on flush).
module sum_window_accumulator
    import sum_stream_pkg::*;
#(
    parameter int IN_W       = SUM_W,
    parameter int ACC_W      = DEFAULT_ACC_W,
    parameter int WINDOW     = DEFAULT_WINDOW,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int CNT_W      = $clog2(WINDOW + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            flush,
    input  logic [IN_W-1:0]                 in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [ACC_W-1:0]                out_data,
    output logic [CNT_W-1:0]                out_count,
    output logic                            out_ovf,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ACC_W:0] MAX_EXT = (ACC_W + 1)'(acc_max(ACC_W));

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sat;

    logic [IN_W-1:0]  fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    logic [ACC_W:0]   sum_ext;
    logic             sum_over;
    logic [ACC_W-1:0] acc_next;
    logic             sat_next;
    logic [CNT_W-1:0] cnt_next;

    // Both ports use valid/ready: a transfer happens on a rising edge where valid && ready;
    // a producer holding valid keeps its data stable until that edge, and out_valid only
    // falls through a transfer, reset or clear.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready && !clear;
    assign pop      = (state == ACCUM) && !fifo_empty && !flush && !clear;

    assign sum_ext  = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, fifo_rdata};
    assign sum_over = (sum_ext > MAX_EXT);
    assign acc_next = sum_over ? MAX_EXT[ACC_W-1:0] : sum_ext[ACC_W-1:0];
    assign sat_next = sat || sum_over;
    assign cnt_next = cnt + 1'b1;

    sum_sync_fifo #(
        .W     (IN_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else if (clear) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (flush && cnt != '0) begin
                        out_data  <= acc;
                        out_count <= cnt;
                        out_ovf   <= sat;
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end else if (pop) begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                        sat <= sat_next;
                        // The sample completing the window is emitted on its own pop edge.
                        if (cnt_next == CNT_W'(WINDOW)) begin
                            out_data  <= acc_next;
                            out_count <= cnt_next;
                            out_ovf   <= sat_next;
                            out_valid <= 1'b1;
                            state     <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        sat       <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_window_accumulator.sv
// Directed bench: window totals, saturation, backpressure, flush and clear priority.
module tb_sum_window_accumulator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       flush = 1'b0;
    logic [4:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic [4:0] out_count;
    logic       out_ovf;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] fifo_level;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected emissions: {ovf, count[4:0], data[7:0]}
    logic [13:0] exp_q[$];
    logic [13:0] mon_e;

    sum_window_accumulator dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .flush      (flush),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_ovf    (out_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [13:0] pack(input logic [7:0] d, input logic [4:0] c, input logic o);
        return {o, c, d};
    endfunction

    // Handshakes are sampled on the falling edge before the edge that completes them.
    always @(negedge clk) begin
        if (!reset && !clear && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", {24'd0, out_data}, {24'd0, mon_e[7:0]});
                check("out_count", {27'd0, out_count}, {27'd0, mon_e[12:8]});
                check("out_ovf", {31'd0, out_ovf}, {31'd0, mon_e[13]});
            end
        end
    end

    task automatic send(input logic [4:0] v);
        logic taken;
        taken = 1'b0;
        in_data  = v;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !taken; i++) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!taken) check("send_timeout", 0, 1);
    endtask

    task automatic send_n(input int n, input logic [4:0] v);
        for (int i = 0; i < n; i++) send(v);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) idle(1);
        check("drain", exp_q.size(), 0);
        idle(2);
    endtask

    task automatic wait_out_valid();
        for (int i = 0; i < 300 && !out_valid; i++) idle(1);
        check("out_valid_seen", {31'd0, out_valid}, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 0);
        check({tag, "_out_data"}, {24'd0, out_data}, 0);
        check({tag, "_out_count"}, {27'd0, out_count}, 0);
        check({tag, "_out_ovf"}, {31'd0, out_ovf}, 0);
        check({tag, "_fifo_level"}, {29'd0, fifo_level}, 0);
    endtask

    initial begin
        int taken;

        // Clock/reset
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b0;
        idle(1);

        // Reset mid-window, then a clean 16x1 window
        send_n(5, 5'd3);
        idle(2);
        #3;
        reset = 1'b1;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        exp_q.push_back(pack(8'd16, 5'd16, 1'b0));
        send_n(16, 5'd1);
        wait_drain();

        // Full window 16x10 with emission latency
        exp_q.push_back(pack(8'd160, 5'd16, 1'b0));
        send_n(16, 5'd10);
        check("lat_after_accept", {31'd0, out_valid}, 0);
        @(negedge clk);
        check("lat_before_pop", {31'd0, out_valid}, 0);
        @(negedge clk);
        check("lat_emit", {31'd0, out_valid}, 1);
        check("lat_data", {24'd0, out_data}, 160);
        idle(1);
        wait_drain();

        // Saturation then a clean window
        exp_q.push_back(pack(8'd255, 5'd16, 1'b1));
        exp_q.push_back(pack(8'd32, 5'd16, 1'b0));
        send_n(16, 5'd31);
        send_n(16, 5'd2);
        wait_drain();

        // Backpressure with a full FIFO
        out_ready = 1'b0;
        exp_q.push_back(pack(8'd64, 5'd16, 1'b0));
        send_n(16, 5'd4);
        wait_out_valid();
        in_data  = 5'd5;
        in_valid = 1'b1;
        taken = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (in_ready) taken++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("bp_accepted", taken, 4);
        check("bp_level", {29'd0, fifo_level}, 4);
        check("bp_in_ready", {31'd0, in_ready}, 0);
        check("bp_hold_valid", {31'd0, out_valid}, 1);
        check("bp_hold_data", {24'd0, out_data}, 64);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(1);
        check("bp_after_hs_valid", {31'd0, out_valid}, 0);
        check("bp_after_hs_level", {29'd0, fifo_level}, 4);
        idle(1);
        check("bp_drain_level", {29'd0, fifo_level}, 3);
        for (int i = 0; i < 40 && taken < 6; i++) begin
            @(negedge clk);
            if (in_ready) taken++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_rest_accepted", taken, 6);
        for (int i = 0; i < 40 && fifo_level != 0; i++) idle(1);
        idle(2);
        exp_q.push_back(pack(8'd30, 5'd6, 1'b0));
        pulse_flush();
        wait_drain();

        // Flush a partial window, then flush an empty one
        exp_q.push_back(pack(8'd24, 5'd3, 1'b0));
        send(5'd7);
        send(5'd8);
        send(5'd9);
        idle(3);
        pulse_flush();
        wait_drain();
        pulse_flush();
        idle(4);
        @(negedge clk);
        check("empty_flush", {31'd0, out_valid}, 0);
        idle(1);

        // Clear beats push, flush and an output handshake
        out_ready = 1'b0;
        send(5'd6);
        send(5'd6);
        idle(3);
        pulse_flush();
        wait_out_valid();
        send(5'd3);
        send(5'd3);
        @(negedge clk);
        check("pre_clear_level", {29'd0, fifo_level}, 2);
        @(posedge clk);
        #1;
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 5'd9;
        flush     = 1'b1;
        out_ready = 1'b1;
        idle(1);
        clear    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check_reset_values("clear");
        idle(1);
        exp_q.push_back(pack(8'd1, 5'd1, 1'b0));
        send(5'd1);
        idle(3);
        pulse_flush();
        wait_drain();

        // Final report
        check("exp_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
